// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter in front of a single-port ram, burst-limited round-robin.
// Define RAM_ARB_FIXED_PRIO_EN to give port A absolute priority instead.
module ram_arbiter #(
  parameter int N         = 6,
  parameter int M         = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req,
  input  logic         a_we,
  input  logic [N-1:0] a_adr,
  input  logic [M-1:0] a_din,
  output logic         a_gnt,
  output logic [M-1:0] a_rdata,
  output logic         a_rvalid,
  input  logic         b_req,
  input  logic         b_we,
  input  logic [N-1:0] b_adr,
  input  logic [M-1:0] b_din,
  output logic         b_gnt,
  output logic [M-1:0] b_rdata,
  output logic         b_rvalid,
  output logic         ram_we,
  output logic [N-1:0] ram_adr,
  output logic [M-1:0] ram_din,
  input  logic [M-1:0] ram_dout
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_b_q, last_b_d;
  logic           a_rvalid_q, a_rvalid_d;
  logic           b_rvalid_q, b_rvalid_d;
  logic [M-1:0]   a_rdata_q, a_rdata_d;
  logic [M-1:0]   b_rdata_q, b_rdata_d;
  logic           pick_a;
  logic           gnt_a, gnt_b;

  // pick_a only matters when A is requesting; a lone B request falls through to B.
  always_comb begin
    pick_a = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    pick_a = a_req;
`else
    if (a_req && !b_req) begin
      pick_a = 1'b1;
    end else if (a_req && b_req) begin
      case (state_q)
        IDLE:    pick_a = last_b_q;
        OWN_A:   pick_a = (cnt_q != CNT_MAX);
        OWN_B:   pick_a = (cnt_q == CNT_MAX);
        default: pick_a = 1'b1;
      endcase
    end
`endif
    gnt_a = !rst && a_req && pick_a;
    gnt_b = !rst && b_req && !pick_a;
  end

  always_comb begin
    ram_we  = 1'b0;
    ram_adr = '0;
    ram_din = '0;
    if (gnt_a) begin
      ram_we  = a_we;
      ram_adr = a_adr;
      ram_din = a_din;
    end else if (gnt_b) begin
      ram_we  = b_we;
      ram_adr = b_adr;
      ram_din = b_din;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_b_d   = last_b_q;
    a_rvalid_d = gnt_a && !a_we;
    b_rvalid_d = gnt_b && !b_we;
    a_rdata_d  = a_rvalid_d ? ram_dout : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? ram_dout : b_rdata_q;
    if (gnt_a) begin
      last_b_d = 1'b0;
      if (state_q == OWN_A) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        state_d = OWN_A;
        cnt_d   = CW'(1);
      end
    end else if (gnt_b) begin
      last_b_d = 1'b1;
      if (state_q == OWN_B) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        state_d = OWN_B;
        cnt_d   = CW'(1);
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_b_q   <= last_b_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a_gnt    = gnt_a;
  assign b_gnt    = gnt_b;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a behavioural ram and read scoreboard.
module tb_ram_arbiter;
  localparam int N = 6;
  localparam int M = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_req, a_we, b_req, b_we;
  logic [N-1:0] a_adr, b_adr;
  logic [M-1:0] a_din, b_din;
  logic         a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [M-1:0] a_rdata, b_rdata;
  logic         ram_we;
  logic [N-1:0] ram_adr;
  logic [M-1:0] ram_din, ram_dout;

  int checks = 0;
  int errors = 0;

  logic [M-1:0] mem [2**N];
  bit           written [2**N];
  logic [M-1:0] ref_mem [2**N];
  bit           ref_written [2**N];
  logic [M-1:0] qa [$];
  logic [M-1:0] qb [$];
  logic [M-1:0] mon_e;

  always #5 clk = ~clk;

  ram_arbiter #(.N(N), .M(M), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_din(a_din),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  function automatic logic [M-1:0] init_word(input logic [N-1:0] adr);
    return {26'd0, adr} * 32'd3 + 32'd7;
  endfunction

  // Ram: sync write, combinational read, unwritten words hold a known pattern.
  assign ram_dout = written[ram_adr] ? mem[ram_adr] : init_word(ram_adr);
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_adr]     <= ram_din;
      written[ram_adr] <= 1'b1;
    end
  end

  function automatic logic [M-1:0] ref_rd(input logic [N-1:0] adr);
    return ref_written[adr] ? ref_mem[adr] : init_word(adr);
  endfunction

  // Scoreboard: a granted read pushes the expected word, the next cycle's rvalid pops it.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      checks++;
      if (qa.size() > 0) begin
        mon_e = qa.pop_front();
        if (a_rvalid !== 1'b1 || a_rdata !== mon_e) begin
          errors++;
          $display("FAIL a_read rvalid=%b rdata=%h want rvalid=1 rdata=%h", a_rvalid, a_rdata, mon_e);
        end
      end else if (a_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL a_rvalid_spurious got %b want 0", a_rvalid);
      end
      checks++;
      if (qb.size() > 0) begin
        mon_e = qb.pop_front();
        if (b_rvalid !== 1'b1 || b_rdata !== mon_e) begin
          errors++;
          $display("FAIL b_read rvalid=%b rdata=%h want rvalid=1 rdata=%h", b_rvalid, b_rdata, mon_e);
        end
      end else if (b_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL b_rvalid_spurious got %b want 0", b_rvalid);
      end
      checks++;
      if (a_gnt && b_gnt) begin
        errors++;
        $display("FAIL dual_grant got a=%b b=%b want at most one", a_gnt, b_gnt);
      end
      if (a_gnt) begin
        if (a_we) begin
          ref_mem[a_adr]     = a_din;
          ref_written[a_adr] = 1'b1;
        end else qa.push_back(ref_rd(a_adr));
      end else if (b_gnt) begin
        if (b_we) begin
          ref_mem[b_adr]     = b_din;
          ref_written[b_adr] = 1'b1;
        end else qb.push_back(ref_rd(b_adr));
      end
    end
  end

  task automatic set_a(input logic req, input logic we, input logic [N-1:0] adr, input logic [M-1:0] din);
    a_req = req; a_we = we; a_adr = adr; a_din = din;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [N-1:0] adr, input logic [M-1:0] din);
    b_req = req; b_we = we; b_adr = adr; b_din = din;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_a(1'b1, 1'b0, 6'd0, 32'd0);
    set_b(1'b1, 1'b1, 6'd1, 32'd9);
    @(negedge clk);
    checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got a=%b b=%b want 0 0", a_gnt, b_gnt); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
    checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got a=%b b=%b want 0 0", a_rvalid, b_rvalid); end
    checks++; if (a_rdata !== 32'd0 || b_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got a=%h b=%h want 0 0", a_rdata, b_rdata); end
    set_a(1'b0, 1'b0, 6'd0, 32'd0);
    set_b(1'b0, 1'b0, 6'd0, 32'd0);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_a_alone();
    next_cycle();
    set_a(1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL a_alone_wr_gnt got a=%b b=%b want 1 0", a_gnt, b_gnt); end
    checks++; if (ram_we !== 1'b1 || ram_adr !== 6'd5 || ram_din !== 32'hDEADBEEF) begin
      errors++; $display("FAIL a_alone_wr_bus got we=%b adr=%0d din=%h want 1 5 deadbeef", ram_we, ram_adr, ram_din);
    end
    next_cycle();
    set_a(1'b1, 1'b0, 6'd5, 32'd0);
    @(negedge clk);
    checks++; if (a_gnt !== 1'b1 || ram_we !== 1'b0 || ram_adr !== 6'd5) begin
      errors++; $display("FAIL a_alone_rd_bus got gnt=%b we=%b adr=%0d want 1 0 5", a_gnt, ram_we, ram_adr);
    end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL a_write_rvalid got %b want 0", a_rvalid); end
    next_cycle();
    set_a(1'b0, 1'b0, 6'd0, 32'd0);
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL a_alone_rdata got rvalid=%b rdata=%h want 1 deadbeef", a_rvalid, a_rdata);
    end
    checks++; if (a_gnt !== 1'b0 || ram_adr !== 6'd0 || ram_din !== 32'd0 || ram_we !== 1'b0) begin
      errors++; $display("FAIL idle_bus got gnt=%b we=%b adr=%0d din=%h want all zero", a_gnt, ram_we, ram_adr, ram_din);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    set_a(1'b1, 1'b0, 6'd5, 32'd0);
    #2;
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL mid_pre_gnt got %b want 1", a_gnt); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (a_gnt !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL mid_rst_gnt got gnt=%b we=%b want 0 0", a_gnt, ram_we); end
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 32'd0) begin
      errors++; $display("FAIL mid_rst_read got rvalid=%b rdata=%h want 0 0", a_rvalid, a_rdata);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL mid_rearb_gnt got %b want 1", a_gnt); end
    next_cycle();
    set_a(1'b0, 1'b0, 6'd0, 32'd0);
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL mid_rearb_rdata got rvalid=%b rdata=%h want 1 deadbeef", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_contention_idle();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_a(1'b1, 1'b0, 6'd1, 32'd0);
    set_b(1'b1, 1'b0, 6'd2, 32'd0);
    @(negedge clk);
    checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || ram_adr !== 6'd1) begin
      errors++; $display("FAIL idle_contention got a=%b b=%b adr=%0d want 1 0 1", a_gnt, b_gnt, ram_adr);
    end
    next_cycle();
    set_a(1'b0, 1'b0, 6'd0, 32'd0);
    @(negedge clk);
    checks++; if (b_gnt !== 1'b1 || ram_adr !== 6'd2) begin
      errors++; $display("FAIL idle_contention_b got b=%b adr=%0d want 1 2", b_gnt, ram_adr);
    end
    next_cycle();
    set_b(1'b0, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic test_burst();
    logic [11:0] pat;
    pat = 12'b1111_0000_1111;
    set_b(1'b1, 1'b0, 6'd3, 32'd0);
    @(negedge clk);
    checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL burst_prime_b got %b want 1", b_gnt); end
    next_cycle();
    set_b(1'b0, 1'b0, 6'd0, 32'd0);
    next_cycle();
    set_a(1'b1, 1'b0, 6'd10, 32'd0);
    set_b(1'b1, 1'b0, 6'd20, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (a_gnt !== pat[11-i] || b_gnt !== !pat[11-i]) begin
        errors++; $display("FAIL burst_cycle%0d got a=%b b=%b want a=%b b=%b", i, a_gnt, b_gnt, pat[11-i], !pat[11-i]);
      end
      next_cycle();
    end
    set_a(1'b0, 1'b0, 6'd0, 32'd0);
    set_b(1'b0, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic test_wrap();
    next_cycle();
    set_b(1'b1, 1'b1, 6'd63, 32'h1);
    @(negedge clk);
    checks++; if (b_gnt !== 1'b1 || ram_we !== 1'b1 || ram_adr !== 6'd63) begin
      errors++; $display("FAIL wrap_b_write got gnt=%b we=%b adr=%0d want 1 1 63", b_gnt, ram_we, ram_adr);
    end
    next_cycle();
    set_b(1'b0, 1'b0, 6'd0, 32'd0);
    set_a(1'b1, 1'b0, 6'd63, 32'd0);
    @(negedge clk);
    checks++; if (a_gnt !== 1'b1 || b_rvalid !== 1'b0) begin
      errors++; $display("FAIL wrap_a_read got gnt=%b b_rvalid=%b want 1 0", a_gnt, b_rvalid);
    end
    next_cycle();
    set_a(1'b1, 1'b0, 6'd0, 32'd0);
    @(negedge clk);
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h1) begin
      errors++; $display("FAIL wrap_rdata63 got rvalid=%b rdata=%h want 1 1", a_rvalid, a_rdata);
    end
    next_cycle();
    set_a(1'b0, 1'b0, 6'd0, 32'd0);
    @(negedge clk);
    checks++; if (a_rdata !== 32'h7) begin errors++; $display("FAIL wrap_word0 got %h want 7", a_rdata); end
  endtask

  task automatic test_fixed_prio();
    int na;
    int nb;
    na = 0;
    nb = 0;
    next_cycle();
    set_a(1'b1, 1'b0, 6'd4, 32'd0);
    set_b(1'b1, 1'b0, 6'd8, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_gnt === 1'b1) na++;
      if (b_gnt === 1'b1) nb++;
      next_cycle();
    end
    checks++; if (na != 10 || nb != 0) begin errors++; $display("FAIL fixed_counts got a=%0d b=%0d want 10 0", na, nb); end
    set_a(1'b0, 1'b0, 6'd0, 32'd0);
    @(negedge clk);
    checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL fixed_b_after_a got %b want 1", b_gnt); end
    next_cycle();
    set_b(1'b0, 1'b0, 6'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_a_alone();
    test_reset_mid();
    test_contention_idle();
`ifdef RAM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_burst();
`endif
    test_wrap();
    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got a=%0d b=%0d want 0 0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
